// File: rtl/if_fetch_buffer_if.sv
// IF/ID side signals of the fetch decoupling buffer; the slave modport is the buffer,
// the master modport is the pipeline (IF stage, ROM data and ID stage) around it.
interface if_fetch_buffer_if;
   logic [31:0] pc_i;
   logic        ce_i;
   logic [31:0] inst_i;
   logic        flush_i;
   logic        id_ready_i;
   logic        if_stall_o;
   logic        id_valid_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;
   logic        id_adel_o;

   modport slave (
      input  pc_i, ce_i, inst_i, flush_i, id_ready_i,
      output if_stall_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o
   );

   modport master (
      output pc_i, ce_i, inst_i, flush_i, id_ready_i,
      input  if_stall_o, id_valid_o, id_pc_o, id_inst_o, id_adel_o
   );
endinterface

// File: rtl/if_fetch_buffer.sv
// IF->ID decoupling buffer: pairs each accepted fetch PC with the next-cycle ROM word and queues it.
// Optional per-entry fetch-address-error flag enabled by defining IF_BUF_ADDR_ERR_EN.
module if_fetch_buffer #(
   parameter int unsigned DEPTH = 4
) (
   input logic          clk_i,
   input logic          rst_i,
   if_fetch_buffer_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pend_v;
   logic [31:0]   pend_pc;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic          accept;
   logic          push;
   logic          pop;
   logic          stall;
   logic          not_empty;
   logic [AW+1:0] occ;

   // Occupancy counts the in-flight fetch so a request is only taken when a slot is guaranteed.
   always_comb begin
      occ       = {1'b0, count} + {{(AW+1){1'b0}}, pend_v};
      stall     = (occ >= (AW+2)'(DEPTH));
      not_empty = (count != '0);
      accept    = bus.ce_i & ~stall & ~bus.flush_i;
      push      = pend_v & ~bus.flush_i;
      pop       = not_empty & bus.id_ready_i & ~bus.flush_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i || bus.flush_i) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         pend_v <= 1'b0;
      end else begin
         pend_v <= accept;
         if (push)
            wr_ptr <= wr_ptr + (AW)'(1);
         if (pop)
            rd_ptr <= rd_ptr + (AW)'(1);
         if (push && !pop)
            count <= count + (AW+1)'(1);
         else if (!push && pop)
            count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept)
         pend_pc <= bus.pc_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i && push) begin
         pc_mem[wr_ptr]   <= pend_pc;
         inst_mem[wr_ptr] <= bus.inst_i;
      end
   end

   assign bus.if_stall_o = stall;
   assign bus.id_valid_o = not_empty;
   assign bus.id_pc_o    = not_empty ? pc_mem[rd_ptr]   : '0;
   assign bus.id_inst_o  = not_empty ? inst_mem[rd_ptr] : '0;

`ifdef IF_BUF_ADDR_ERR_EN
   logic pend_adel;
   logic adel_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (accept)
         pend_adel <= (bus.pc_i[1:0] != 2'b00);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i && push)
         adel_mem[wr_ptr] <= pend_adel;
   end

   assign bus.id_adel_o = not_empty ? adel_mem[rd_ptr] : 1'b0;
`else
   assign bus.id_adel_o = 1'b0;
`endif
endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed self-checking bench for if_fetch_buffer (DEPTH 4) with a one-cycle-latency ROM model.
module tb_if_fetch_buffer;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   if_fetch_buffer_if bus ();

   if_fetch_buffer #(.DEPTH(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      return a ^ 32'hDEAD_BEEF;
   endfunction

   // ROM answers the address presented in the previous cycle.
   always @(posedge clk) bus.inst_i <= rom(bus.pc_i);

`ifdef IF_BUF_ADDR_ERR_EN
   localparam logic EXP_ADEL6 = 1'b1;
`else
   localparam logic EXP_ADEL6 = 1'b0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst            = 1'b0;
      bus.ce_i       = 1'b1;
      bus.pc_i       = 32'hBFC0_0000;
      bus.flush_i    = 1'b0;
      bus.id_ready_i = 1'b0;

      // reset held two edges with ce high
      tick();
      tick();
      chk("rst_valid", bus.id_valid_o, 0);
      chk("rst_stall", bus.if_stall_o, 0);
      chk("rst_pc",    bus.id_pc_o,    0);
      chk("rst_inst",  bus.id_inst_o,  0);
      chk("rst_adel",  bus.id_adel_o,  0);
      rst = 1'b1;
      bus.ce_i = 1'b0;
      tick();
      tick();
      chk("post_rst_empty", bus.id_valid_o, 0);

      // first fetch: visible two cycles after the request
      bus.ce_i = 1'b1;
      tick();
      bus.ce_i = 1'b0;
      chk("lat_t1_valid", bus.id_valid_o, 0);
      tick();
      chk("lat_t2_valid", bus.id_valid_o, 1);
      chk("lat_t2_pc",    bus.id_pc_o,    32'hBFC0_0000);
      chk("lat_t2_inst",  bus.id_inst_o,  rom(32'hBFC0_0000));
      bus.id_ready_i = 1'b1;
      tick();
      chk("lat_pop_empty", bus.id_valid_o, 0);

      // streaming: one entry per cycle, never stalled
      bus.ce_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.pc_i = 32'(4 * i);
         tick();
         chk("stream_stall", bus.if_stall_o, 0);
         if (i >= 1) begin
            chk("stream_pc",   bus.id_pc_o,   32'(4 * (i - 1)));
            chk("stream_inst", bus.id_inst_o, rom(32'(4 * (i - 1))));
         end
      end
      bus.ce_i = 1'b0;
      tick();
      chk("stream_last_pc", bus.id_pc_o, 32'h1C);
      tick();
      chk("stream_drained", bus.id_valid_o, 0);

      // back-pressure: ID stalled, IF holds pc while full
      bus.id_ready_i = 1'b0;
      bus.ce_i = 1'b1;
      bus.pc_i = 32'h100; tick();
      bus.pc_i = 32'h104; tick();
      bus.pc_i = 32'h108; tick();
      chk("full_sum3_stall", bus.if_stall_o, 0);
      bus.pc_i = 32'h10C; tick();
      chk("full_sum4_stall", bus.if_stall_o, 1);
      bus.pc_i = 32'h110; tick();
      chk("full_c4_stall", bus.if_stall_o, 1);
      chk("full_head_pc",  bus.id_pc_o,    32'h100);
      tick();
      chk("full_hold_stall", bus.if_stall_o, 1);
      chk("full_hold_pc",    bus.id_pc_o,    32'h100);
      chk("full_hold_inst",  bus.id_inst_o,  rom(32'h100));
      bus.id_ready_i = 1'b1;
      tick();
      chk("bp_stall_fall", bus.if_stall_o, 0);
      chk("bp_pop1_pc",    bus.id_pc_o,    32'h104);
      tick();
      chk("bp_pop2_pc", bus.id_pc_o, 32'h108);
      bus.pc_i = 32'h114;
      tick();
      chk("bp_pushpop_pc", bus.id_pc_o, 32'h10C);
      bus.ce_i = 1'b0;
      tick();
      chk("bp_wrap_pc",   bus.id_pc_o,   32'h110);
      chk("bp_wrap_inst", bus.id_inst_o, rom(32'h110));
      tick();
      chk("bp_last_pc",   bus.id_pc_o,   32'h114);
      chk("bp_last_inst", bus.id_inst_o, rom(32'h114));
      tick();
      chk("bp_drained", bus.id_valid_o, 0);

      // flush with a queued entry and a fetch in flight
      bus.id_ready_i = 1'b0;
      bus.ce_i = 1'b1;
      bus.pc_i = 32'h0C; tick();
      bus.pc_i = 32'h10; tick();
      chk("fl_pre_pc", bus.id_pc_o, 32'h0C);
      bus.flush_i = 1'b1;
      bus.pc_i = 32'h14;
      tick();
      bus.flush_i = 1'b0;
      bus.ce_i = 1'b0;
      chk("fl_valid", bus.id_valid_o, 0);
      chk("fl_pc",    bus.id_pc_o,    0);
      tick();
      chk("fl_discard", bus.id_valid_o, 0);
      bus.ce_i = 1'b1;
      bus.pc_i = 32'h20;
      tick();
      bus.ce_i = 1'b0;
      tick();
      chk("fl_after_pc",   bus.id_pc_o,   32'h20);
      chk("fl_after_inst", bus.id_inst_o, rom(32'h20));
      bus.id_ready_i = 1'b1;
      tick();
      chk("fl_after_empty", bus.id_valid_o, 0);

      // address-error flag
      bus.id_ready_i = 1'b0;
      bus.ce_i = 1'b1;
      bus.pc_i = 32'h6; tick();
      bus.pc_i = 32'h8; tick();
      bus.ce_i = 1'b0;
      chk("adel6_pc",   bus.id_pc_o,   32'h6);
      chk("adel6_inst", bus.id_inst_o, rom(32'h6));
      chk("adel6_flag", bus.id_adel_o, 32'(EXP_ADEL6));
      bus.id_ready_i = 1'b1;
      tick();
      chk("adel8_pc",   bus.id_pc_o,   32'h8);
      chk("adel8_flag", bus.id_adel_o, 0);
      tick();
      chk("adel_empty", bus.id_valid_o, 0);

      // reset mid-operation drops queued entries
      bus.id_ready_i = 1'b0;
      bus.ce_i = 1'b1;
      bus.pc_i = 32'h40; tick();
      bus.pc_i = 32'h44; tick();
      chk("mrst_pre_valid", bus.id_valid_o, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.ce_i = 1'b0;
      chk("mrst_valid", bus.id_valid_o, 0);
      chk("mrst_stall", bus.if_stall_o, 0);
      tick();
      chk("mrst_no_push", bus.id_valid_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/if_fetch_buffer.md
# if_fetch_buffer

Decoupling buffer between the IF stage and the ID stage. Captures each accepted fetch PC, pairs it with the instruction the ROM returns one cycle later, and queues the {pc, inst} pair in a small FIFO drained by ID under a valid/ready handshake. Provides back-pressure to IF so the PC holds while the buffer is full. Supports a pipeline flush from branch/exception resolution.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, synchronous, active-low
- pc_i  in  32  fetch PC from IF
- ce_i  in  1  IF fetch enable; high = ROM read issued at pc_i this cycle
- inst_i  in  32  ROM read data, valid the cycle after the request
- flush_i  in  1  discard all queued and in-flight fetches
- id_ready_i  in  1  ID accepts head entry this cycle
- if_stall_o  out  1  IF must hold pc_i; request not accepted
- id_valid_o  out  1  head entry valid
- id_pc_o  out  32  head entry PC
- id_inst_o  out  32  head entry instruction
- id_adel_o  out  1  head entry fetch-address-error flag

## Operation
- Request accepted in cycle t iff ce_i & ~if_stall_o & ~flush_i; pc_i (and adel flag) latched into pending register, pend_v set.
- Cycle t+1 with pend_v: {pend_pc, inst_i, pend_adel} pushed into FIFO tail; pend_v cleared unless a new request is accepted the same cycle (back-to-back requests sustain one push per cycle).
- Pop: id_valid_o & id_ready_i at rising edge advances head.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Occupancy rule: if_stall_o = (count + pend_v) ≥ DEPTH. Conservative: ignores a same-cycle pop. Combinational from registered state only.
- Pointers log2(DEPTH) bits, wrap modulo DEPTH; count log2(DEPTH)+1 bits, range 0..DEPTH.
- id_valid_o = (count != 0). When empty, id_pc_o/id_inst_o/id_adel_o drive 0.
- Flush (priority over push, pop and new request): next cycle count = 0, pointers = 0, pend_v = 0; instruction returned in the cycle after flush is discarded. Request presented in the flush cycle is not accepted.
- ID may deassert id_ready_i at any time; head entry and outputs remain stable while id_valid_o & ~id_ready_i.

## Timing
- Reset (rst_i low at a rising edge): count, pointers, pend_v = 0; if_stall_o = 0, id_valid_o = 0, id_pc_o = 0, id_inst_o = 0, id_adel_o = 0. Reset mid-operation drops pending and queued entries identically to flush.
- Fetch-to-ID latency: request in cycle t → entry visible on id_* in cycle t+2 (min).
- Throughput: one entry per cycle in and out at steady state with id_ready_i high.
- Full: with DEPTH entries stored, no push possible; if_stall_o is high, so no request is ever in flight without a free slot.
- if_stall_o falls the cycle after the pop that frees a slot.

## Configuration
- IF_BUF_ADDR_ERR_EN defined: at request acceptance, adel = (pc_i[1:0] != 2'b00); flag stored per entry and presented on id_adel_o with the entry. Misaligned fetch still occupies a slot; inst_i captured unchanged.
- Not defined: no adel storage; id_adel_o tied 0.

## Test plan
- Reset: hold rst_i low 2 cycles with ce_i high → all outputs 0, no entry after release until a new request; first request pc 0xBFC00000 → id_valid_o high 2 cycles later with id_pc_o 0xBFC00000, id_inst_o = ROM word.
- Streaming: ce_i high, PCs 0x0, 0x4, 0x8…, id_ready_i high → one entry per cycle in order, if_stall_o never high.
- Full/back-pressure: id_ready_i low, 6 requests with DEPTH 4 → if_stall_o high once count+pend = 4, exactly 4 entries stored; raise id_ready_i → entries pop in order, if_stall_o falls one cycle after first pop, held PC fetched next.
- Flush with request in flight: flush_i in cycle after request 0x10 → returned word discarded, id_valid_o low next cycle, count 0.
- Simultaneous push/pop at count 2 → count stays 2, pointers wrap correctly past DEPTH-1.
- With IF_BUF_ADDR_ERR_EN: request pc 0x00000006 → entry with id_adel_o = 1; pc 0x00000008 → id_adel_o = 0; without macro id_adel_o always 0.
